// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and helpers for the up/down counter.
// Multi-digit helpers take 64-bit packed-BCD operands, so counters are limited to 16 digits.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;
    localparam int BCD_MAX_DIGITS = 16;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

    // a >= b over the low 'digits' digits; the most significant differing digit decides
    function automatic logic bcd_ge(input logic [63:0] a, input logic [63:0] b, input int digits);
        logic res;
        logic done;
        res  = 1'b1;
        done = 1'b0;
        for (int i = BCD_MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < digits && !done && a[4*i +: 4] != b[4*i +: 4]) begin
                res  = a[4*i +: 4] > b[4*i +: 4];
                done = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the increment/decrement ripple chain; purely combinational.
// step_out is a carry (9->0, up) or a borrow (0->9, down) into the next digit.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       up,
    input  logic       step_in,
    output logic [3:0] digit_nxt,
    output logic       step_out
);

    always_comb begin
        digit_nxt = digit;
        step_out  = 1'b0;
        if (step_in) begin
            if (up) begin
                if (digit >= BCD_MAX) begin
                    digit_nxt = BCD_MIN;
                    step_out  = 1'b1;
                end else begin
                    digit_nxt = digit + 4'd1;
                end
            end else begin
                if (digit == BCD_MIN) begin
                    digit_nxt = BCD_MAX;
                    step_out  = 1'b1;
                end else begin
                    digit_nxt = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with load, programmable max and wrap/saturate ends.
// count/tc are registered one clock after the qualifying input; no backpressure.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int                    DIGITS  = 2,
    parameter logic [4*DIGITS-1:0]   RST_VAL = {DIGITS{4'h9}},
    parameter bit                    WRAP    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   max_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  bcd_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]    max_c;
    logic [W-1:0]    ld_c;
    logic [W-1:0]    step_val;
    logic [W-1:0]    count_nxt;
    logic [DIGITS:0] step;
    logic            ld_bad;
    logic            ld_over;
    logic            term;
    logic            tc_nxt;
    logic            err_nxt;

    always_comb begin
        max_c  = '0;
        ld_c   = '0;
        ld_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            max_c[4*k +: 4] = bcd_clamp(max_val[4*k +: 4]);
            ld_c[4*k +: 4]  = bcd_clamp(load_val[4*k +: 4]);
            if (load_val[4*k +: 4] > BCD_MAX) begin
                ld_bad = 1'b1;
            end
        end
    end

    assign step[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_cell u_cell (
            .digit     (count[4*k +: 4]),
            .up        (up),
            .step_in   (step[k]),
            .digit_nxt (step_val[4*k +: 4]),
            .step_out  (step[k+1])
        );
    end

    // A borrow out of the top digit happens exactly when count is all zeros.
    assign term    = up ? bcd_ge(64'(count), 64'(max_c), DIGITS) : step[DIGITS];
    assign ld_over = !bcd_ge(64'(max_c), 64'(ld_c), DIGITS);

    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        err_nxt   = bcd_err;
        if (load) begin
            if (ld_over) begin
                count_nxt = max_c;
                err_nxt   = 1'b1;
            end else begin
                count_nxt = ld_c;
                err_nxt   = bcd_err | ld_bad;
            end
        end else if (en) begin
            if (term) begin
                tc_nxt = 1'b1;
                if (up) begin
                    count_nxt = WRAP ? '0 : max_c;
                end else begin
                    count_nxt = WRAP ? max_c : '0;
                end
            end else begin
                count_nxt = step_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= RST_VAL;
            tc      <= 1'b0;
            bcd_err <= 1'b0;
        end else begin
            count   <= count_nxt;
            tc      <= tc_nxt;
            bcd_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: a wrapping and a saturating instance share stimulus.
module tb_bcd_updown_counter;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [7:0] load_val, max_val;
    logic [7:0] count1, count0;
    logic       tc1, tc0, err1, err0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .RST_VAL(8'h99), .WRAP(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val),
        .count(count1), .tc(tc1), .bcd_err(err1)
    );

    bcd_updown_counter #(.DIGITS(2), .RST_VAL(8'h99), .WRAP(1'b0)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val),
        .count(count0), .tc(tc0), .bcd_err(err0)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0;
        load_val = 8'h00; max_val = 8'h99;
        tick();
        n_cmp++; if (count1 !== 8'h99) begin n_bad++; $display("FAIL reset_count: got %h expected 99", count1); end
        n_cmp++; if (tc1 !== 1'b0)     begin n_bad++; $display("FAIL reset_tc: got %b expected 0", tc1); end
        n_cmp++; if (err1 !== 1'b0)    begin n_bad++; $display("FAIL reset_err: got %b expected 0", err1); end
        n_cmp++; if (count0 !== 8'h99) begin n_bad++; $display("FAIL reset_count_sat: got %h expected 99", count0); end
        reset = 1'b0;
    endtask

    task automatic test_countdown_wrap;
        logic [7:0] exp;
        en = 1'b1; up = 1'b0; max_val = 8'h99;
        for (int i = 0; i < 100; i++) begin
            tick();
            exp = (i == 99) ? 8'h99 : to_bcd(98 - i);
            n_cmp++; if (count1 !== exp) begin n_bad++; $display("FAIL down_count[%0d]: got %h expected %h", i, count1, exp); end
            n_cmp++; if (tc1 !== (i == 99)) begin n_bad++; $display("FAIL down_tc[%0d]: got %b expected %b", i, tc1, (i == 99)); end
        end
        n_cmp++; if (count0 !== 8'h00) begin n_bad++; $display("FAIL down_sat_hold: got %h expected 00", count0); end
        n_cmp++; if (tc0 !== 1'b1)     begin n_bad++; $display("FAIL down_sat_tc: got %b expected 1", tc0); end
        en = 1'b0;
    endtask

    task automatic test_borrow_carry;
        load = 1'b1; load_val = 8'h19; en = 1'b0;
        tick();
        n_cmp++; if (count1 !== 8'h19) begin n_bad++; $display("FAIL load_19: got %h expected 19", count1); end
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        n_cmp++; if (count1 !== 8'h18) begin n_bad++; $display("FAIL dec_19: got %h expected 18", count1); end
        n_cmp++; if (tc1 !== 1'b0)     begin n_bad++; $display("FAIL dec_19_tc: got %b expected 0", tc1); end
        en = 1'b0; load = 1'b1; load_val = 8'h20;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        n_cmp++; if (count1 !== 8'h19) begin n_bad++; $display("FAIL borrow_20: got %h expected 19", count1); end
        en = 1'b0; load = 1'b1; load_val = 8'h09;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        n_cmp++; if (count1 !== 8'h10) begin n_bad++; $display("FAIL carry_09: got %h expected 10", count1); end
        n_cmp++; if (count0 !== 8'h10) begin n_bad++; $display("FAIL carry_09_sat: got %h expected 10", count0); end
        en = 1'b0;
    endtask

    task automatic test_saturate;
        logic [7:0] e0 [5] = '{8'h44, 8'h45, 8'h45, 8'h45, 8'h45};
        logic       t0 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] e1 [5] = '{8'h44, 8'h45, 8'h00, 8'h01, 8'h02};
        logic       t1 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] d1 [3] = '{8'h00, 8'h45, 8'h44};
        logic       dt0 [3] = '{1'b0, 1'b1, 1'b1};
        logic       dt1 [3] = '{1'b0, 1'b1, 1'b0};
        max_val = 8'h45; load = 1'b1; load_val = 8'h43;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (count0 !== e0[i]) begin n_bad++; $display("FAIL sat_up[%0d]: got %h expected %h", i, count0, e0[i]); end
            n_cmp++; if (tc0 !== t0[i])    begin n_bad++; $display("FAIL sat_up_tc[%0d]: got %b expected %b", i, tc0, t0[i]); end
            n_cmp++; if (count1 !== e1[i]) begin n_bad++; $display("FAIL wrap_up[%0d]: got %h expected %h", i, count1, e1[i]); end
            n_cmp++; if (tc1 !== t1[i])    begin n_bad++; $display("FAIL wrap_up_tc[%0d]: got %b expected %b", i, tc1, t1[i]); end
        end
        en = 1'b0; load = 1'b1; load_val = 8'h01;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (count0 !== 8'h00) begin n_bad++; $display("FAIL sat_dn[%0d]: got %h expected 00", i, count0); end
            n_cmp++; if (tc0 !== dt0[i])   begin n_bad++; $display("FAIL sat_dn_tc[%0d]: got %b expected %b", i, tc0, dt0[i]); end
            n_cmp++; if (count1 !== d1[i]) begin n_bad++; $display("FAIL wrap_dn[%0d]: got %h expected %h", i, count1, d1[i]); end
            n_cmp++; if (tc1 !== dt1[i])   begin n_bad++; $display("FAIL wrap_dn_tc[%0d]: got %b expected %b", i, tc1, dt1[i]); end
        end
        en = 1'b0; max_val = 8'h99;
    endtask

    task automatic test_bcd_err;
        reset = 1'b1;
        tick();
        reset = 1'b0; max_val = 8'h99; load = 1'b1; load_val = 8'h3C;
        tick();
        n_cmp++; if (count1 !== 8'h39) begin n_bad++; $display("FAIL clamp_3C: got %h expected 39", count1); end
        n_cmp++; if (err1 !== 1'b1)    begin n_bad++; $display("FAIL clamp_err: got %b expected 1", err1); end
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (count1 !== to_bcd(40 + i)) begin n_bad++; $display("FAIL err_count[%0d]: got %h expected %h", i, count1, to_bcd(40 + i)); end
            n_cmp++; if (err1 !== 1'b1) begin n_bad++; $display("FAIL err_sticky[%0d]: got %b expected 1", i, err1); end
        end
        en = 1'b0; reset = 1'b1;
        tick();
        n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b expected 0", err1); end
        reset = 1'b0; max_val = 8'h50; load = 1'b1; load_val = 8'h72;
        tick();
        n_cmp++; if (count1 !== 8'h50) begin n_bad++; $display("FAIL load_over_max: got %h expected 50", count1); end
        n_cmp++; if (err0 !== 1'b1)    begin n_bad++; $display("FAIL load_over_err: got %b expected 1", err0); end
        load = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; max_val = 8'h9F; load = 1'b1; load_val = 8'h99;
        tick();
        n_cmp++; if (count1 !== 8'h99) begin n_bad++; $display("FAIL max_clamp_load: got %h expected 99", count1); end
        n_cmp++; if (err1 !== 1'b0)    begin n_bad++; $display("FAIL max_clamp_err: got %b expected 0", err1); end
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        n_cmp++; if (count1 !== 8'h00) begin n_bad++; $display("FAIL max_clamp_wrap: got %h expected 00", count1); end
        n_cmp++; if (tc1 !== 1'b1)     begin n_bad++; $display("FAIL max_clamp_tc: got %b expected 1", tc1); end
        en = 1'b0; max_val = 8'h99;
    endtask

    task automatic test_priority;
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b1; up = 1'b1; max_val = 8'h99;
        tick();
        n_cmp++; if (tc1 !== 1'b1) begin n_bad++; $display("FAIL prio_setup_tc: got %b expected 1", tc1); end
        reset = 1'b1; load = 1'b1; load_val = 8'h25;
        tick();
        n_cmp++; if (count1 !== 8'h99) begin n_bad++; $display("FAIL prio_reset: got %h expected 99", count1); end
        n_cmp++; if (tc1 !== 1'b0)     begin n_bad++; $display("FAIL prio_reset_tc: got %b expected 0", tc1); end
        reset = 1'b0;
        tick();
        n_cmp++; if (count1 !== 8'h25) begin n_bad++; $display("FAIL prio_load: got %h expected 25", count1); end
        n_cmp++; if (tc1 !== 1'b0)     begin n_bad++; $display("FAIL prio_load_tc: got %b expected 0", tc1); end
        load = 1'b0; en = 1'b0;
        tick();
        n_cmp++; if (count1 !== 8'h25) begin n_bad++; $display("FAIL hold: got %h expected 25", count1); end
    endtask

    task automatic test_max_lower;
        max_val = 8'h99; load = 1'b1; load_val = 8'h70;
        tick();
        load = 1'b0; max_val = 8'h50; en = 1'b1; up = 1'b1;
        tick();
        n_cmp++; if (count1 !== 8'h00) begin n_bad++; $display("FAIL lower_up_wrap: got %h expected 00", count1); end
        n_cmp++; if (tc1 !== 1'b1)     begin n_bad++; $display("FAIL lower_up_tc: got %b expected 1", tc1); end
        n_cmp++; if (count0 !== 8'h50) begin n_bad++; $display("FAIL lower_up_sat: got %h expected 50", count0); end
        en = 1'b0; max_val = 8'h99; load = 1'b1;
        tick();
        load = 1'b0; max_val = 8'h50; en = 1'b1; up = 1'b0;
        tick();
        n_cmp++; if (count1 !== 8'h69) begin n_bad++; $display("FAIL lower_dn: got %h expected 69", count1); end
        n_cmp++; if (tc1 !== 1'b0)     begin n_bad++; $display("FAIL lower_dn_tc: got %b expected 0", tc1); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown_wrap();
        test_borrow_carry();
        test_saturate();
        test_bcd_err();
        test_priority();
        test_max_lower();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parameterised N-digit BCD counter. Counts up or down, with parallel load, a runtime-programmable maximum, and wrap or saturate behaviour at the ends of the range.
- Drives 7-segment display digit decoders and countdown/timer control logic.
- Generalises the fixed 2-digit 99→00 down-counter to any digit count, both directions and a programmable range.

Parameters:
- DIGITS, 2, number of BCD digits; count width W = 4*DIGITS.
- RST_VAL, all digits 9 (8'h99 for DIGITS=2), packed-BCD value loaded on reset.
- WRAP, 1, 1 = wrap at range ends; 0 = saturate at range ends.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable, active-high; one step per enabled cycle.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load strobe.
- load_val  input  W  packed-BCD load value; digit k at [4k+3:4k].
- max_val  input  W  packed-BCD upper bound of the count range (range is 0..max_val).
- count  output  W  packed-BCD count, registered.
- tc  output  1  terminal-count pulse, registered.
- bcd_err  output  1  sticky flag: an invalid digit was loaded or clamped.

Behaviour:
- Priority on each rising edge: reset > load > en. With en=0 and load=0, count holds and tc=0.
- Reset: count=RST_VAL, tc=0, bcd_err=0. Reset mid-count takes effect on the next edge regardless of en or load.
- Load:
  - Each load_val digit >9 is clamped to 9 and sets bcd_err.
  - If the clamped value > max_val, count=max_val and bcd_err is set.
  - tc=0 on a load cycle.
- Count-up step (en=1, up=1):
  - If count >= max_val (terminal-up), count becomes 0 when WRAP=1, or max_val when WRAP=0.
  - Otherwise digit0 increments. A digit going 9→0 carries into the next digit. Carry ripples within the same cycle.
- Count-down step (en=1, up=0):
  - If count == 0 (terminal-down), count becomes max_val when WRAP=1, or holds 0 when WRAP=0.
  - Otherwise digit0 decrements. A digit going 0→9 borrows from the next digit.
  - Down-count from above max_val (after max_val is lowered) decrements normally. No clamp.
- tc:
  - tc=1 for exactly the cycle after any enabled step taken from a terminal state, in the active direction; otherwise 0.
  - With WRAP=0, tc re-pulses on every enabled cycle while held at the terminal value.
- Latency: count and tc update one clock after the qualifying input. No combinational path from inputs to outputs.
- bcd_err: cleared only by reset.
- max_val:
  - Sampled every cycle; it is not registered. Changing it mid-count is legal.
  - Digits >9 in max_val are treated as 9. This does not set bcd_err.
- up may change on any cycle; the new direction applies to that cycle's step.
- Output digits are always valid BCD (0..9) in every state.

Decomposition:
- Shared package bcd_pkg:
  - BCD_MAX=4'd9 and BCD_MIN=4'd0.
  - Function bcd_clamp(digit).
  - Function bcd_ge(a,b,DIGITS) for multi-digit BCD compare.
- Sub-module bcd_digit_cell, instantiated DIGITS times via generate:
  - Inputs: step_in (carry/borrow in), up, digit value.
  - Outputs: next digit, step_out (carry out on 9→0 up, borrow out on 0→9 down).
- Top level holds the registers, terminal detection, load/clamp logic, tc and bcd_err.

Test Plan:
- Reset, then 100 cycles of en=1, up=0, WRAP=1, max_val=99 → count 99,98,…,00, then 99. tc high one cycle, immediately after the 00→99 step.
- count=19; one step en=1, up=0 → 18. Load 20, one down step → 19 (borrow across digits). Load 09, one up step → 10 (carry).
- WRAP=0, max_val=45, load 43, en=1, up=1 for 5 cycles → 44,45,45,45,45. tc=1 on each of the last 3 cycles. With up=0 from 01 → 00 held, tc pulses.
- load_val=8'h3C with max_val=99 → count=39, bcd_err=1. bcd_err stays 1 through further counting until reset.
- Simultaneous reset=1, load=1, en=1 → count=RST_VAL (99), tc=0. Load=1 with en=1 → loaded value wins, no step that cycle.
- count=70, max_val lowered to 50, en=1, up=1 → count 0 (WRAP=1), tc pulses. Same setup with up=0 → 69.
